// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver.
// The line is synchronised, each start edge is qualified at mid-bit, and
// DBIT data bits plus one stop bit are sampled at baud-period intervals.
// A good frame gives a one-cycle o_valid with the byte on o_data. A low
// stop bit gives a one-cycle o_frame_err, and the receiver then waits for
// the line to return high before it looks for a new start edge.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | line idle, waiting for rx_s low (start edge)
// ST_START | counting to mid start bit to reject glitches
// ST_DATA  | sampling DBIT data bits, LSB first, one per baud period
// ST_STOP  | sampling the stop bit; high = good byte, low = framing error
// ST_BREAK | framing error seen, waiting for the line to go high again

module uart_rx #(
  parameter int CLKS_PER_BAUD = 1458,
  parameter int DBIT          = 8
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_uart_rx,
  output logic [DBIT-1:0] o_data,
  output logic            o_valid,
  output logic            o_frame_err,
  output logic            o_busy
);

  localparam int CW   = $clog2(CLKS_PER_BAUD);
  localparam int HALF = CLKS_PER_BAUD / 2;
  localparam int IW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BAUD - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   baud_cnt;
  logic [IW-1:0]   bit_idx;
  logic [DBIT-1:0] shreg;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with baud down-counter, shift register and registered strobes.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= ST_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            baud_cnt <= HALF_LD;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_cnt == '0) begin
            if (rx_s) begin
              // Line back high at mid start bit: glitch, drop it silently.
              state <= ST_IDLE;
            end else begin
              baud_cnt <= FULL_LD;
              bit_idx  <= '0;
              state    <= ST_DATA;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        ST_DATA: begin
          if (baud_cnt == '0) begin
            // Shift right so that the first bit received ends at bit 0.
            shreg    <= {rx_s, shreg[DBIT-1:1]};
            baud_cnt <= FULL_LD;
            if (bit_idx == IDX_LAST) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        ST_STOP: begin
          if (baud_cnt == '0) begin
            if (rx_s) begin
              // Going idle at mid stop bit allows back-to-back frames.
              o_data  <= shreg;
              o_valid <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= ST_BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        ST_BREAK: begin
          // A held-low line must not look like a stream of start bits.
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames at chosen bit times and compares each
// strobe against a queue of expected frame outcomes.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPB    = 16;
  localparam int DBIT   = 8;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = CPB * CLK_NS;

  logic            i_clk = 1'b0;
  logic            i_rstn = 1'b0;
  logic            i_uart_rx = 1'b1;
  logic [DBIT-1:0] o_data;
  logic            o_valid;
  logic            o_frame_err;
  logic            o_busy;

  uart_rx #(.CLKS_PER_BAUD(CPB), .DBIT(DBIT)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_uart_rx  (i_uart_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  always #(CLK_NS/2) i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: each entry is {kind, byte}; kind 1 = good byte, 2 = framing error.
  logic [31:0] exp_q[$];
  logic [7:0]  last_good = 8'h00;
  int          n_valid_exp = 0;
  int          n_err_exp = 0;
  int          n_valid_seen = 0;
  int          n_err_seen = 0;
  logic [31:0] e;

  task automatic expect_byte(input logic [7:0] d);
    exp_q.push_back({16'h0, 8'h01, d});
    n_valid_exp++;
  endtask

  task automatic expect_err();
    exp_q.push_back({16'h0, 8'h02, 8'h00});
    n_err_exp++;
  endtask

  // Serial frame: start, 8 data bits LSB first, stop level as given.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_ns);
    i_uart_rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = d[i];
      #(bit_ns);
    end
    i_uart_rx = stop;
    #(bit_ns);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_busy) && k < 4000) begin
      @(posedge i_clk);
      k++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Strobe monitor: sampled on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    if (i_rstn && (o_valid || o_frame_err)) begin
      if (o_valid && o_frame_err) chk("both_strobes", 32'(o_valid & o_frame_err), 0);
      if (o_valid) n_valid_seen++;
      if (o_frame_err) n_err_seen++;
      chk("strobe_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (o_valid) begin
          chk("kind_valid", 1, {24'h0, e[15:8]});
          chk("rx_data", {24'h0, o_data}, {24'h0, e[7:0]});
          last_good = e[7:0];
        end else begin
          chk("kind_err", 2, {24'h0, e[15:8]});
          chk("data_hold", {24'h0, o_data}, {24'h0, last_good});
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic [7:0] c3;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_data",  {24'h0, o_data}, 0);
    chk("rst_valid", {31'h0, o_valid}, 0);
    chk("rst_ferr",  {31'h0, o_frame_err}, 0);
    chk("rst_busy",  {31'h0, o_busy}, 0);
    i_rstn = 1'b1;
    repeat (5) @(posedge i_clk);

    // 1: single frame
    @(negedge i_clk);
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1, BIT_NS);
    drain("t1_drain");
    chk("t1_data", {24'h0, o_data}, 32'hA5);
    chk("t1_no_err", n_err_seen, 0);

    // 2: back-to-back with no idle gap
    @(negedge i_clk);
    expect_byte(8'h00);
    expect_byte(8'hFF);
    expect_byte(8'h5A);
    send_frame(8'h00, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b1, BIT_NS);
    send_frame(8'h5A, 1'b1, BIT_NS);
    drain("t2_drain");
    chk("t2_count", n_valid_seen, 4);

    // 3: 5-clock glitch is rejected at mid start bit
    repeat (4) @(posedge i_clk);
    #1;
    i_uart_rx = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    chk("t3_busy_start", {31'h0, o_busy}, 1);
    i_uart_rx = 1'b1;
    repeat (7) @(posedge i_clk);
    #1;
    chk("t3_idle", {31'h0, o_busy}, 0);
    chk("t3_data_hold", {24'h0, o_data}, 32'h5A);
    chk("t3_no_strobe", n_valid_seen, 4);

    // 4: framing error, held break, then recovery
    @(negedge i_clk);
    expect_err();
    send_frame(8'h3C, 1'b0, BIT_NS);
    #(40 * CLK_NS);
    chk("t4_err_seen", n_err_seen, 1);
    chk("t4_break_busy", {31'h0, o_busy}, 1);
    chk("t4_data_hold", {24'h0, o_data}, 32'h5A);
    i_uart_rx = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    chk("t4_break_exit", {31'h0, o_busy}, 0);
    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1, BIT_NS);
    drain("t4_drain");
    chk("t4_data", {24'h0, o_data}, 32'h81);

    // 5: sender baud skewed by about +3% and -3%
    @(negedge i_clk);
    expect_byte(8'h96);
    send_frame(8'h96, 1'b1, (BIT_NS * 103 + 50) / 100);
    #(2 * BIT_NS);
    @(negedge i_clk);
    expect_byte(8'h96);
    send_frame(8'h96, 1'b1, (BIT_NS * 97 + 50) / 100);
    drain("t5_drain");
    chk("t5_count", n_valid_seen, 7);

    // 6: reset in the middle of the data bits
    @(negedge i_clk);
    c3 = 8'hC3;
    i_uart_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      i_uart_rx = c3[i];
      #(BIT_NS);
    end
    i_uart_rx = c3[3];
    #(BIT_NS / 2);
    chk("t6_busy_pre", {31'h0, o_busy}, 1);
    i_rstn = 1'b0;
    #1;
    last_good = 8'h00;
    chk("t6_rst_data",  {24'h0, o_data}, 0);
    chk("t6_rst_valid", {31'h0, o_valid}, 0);
    chk("t6_rst_ferr",  {31'h0, o_frame_err}, 0);
    chk("t6_rst_busy",  {31'h0, o_busy}, 0);
    i_uart_rx = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    repeat (20) @(posedge i_clk);
    chk("t6_no_strobe", n_valid_seen, 7);
    @(negedge i_clk);
    expect_byte(8'h42);
    send_frame(8'h42, 1'b1, BIT_NS);
    drain("t6_drain");
    chk("t6_data", {24'h0, o_data}, 32'h42);

    // Random stream of 256 bytes with random idle gaps (including none)
    @(negedge i_clk);
    for (int n = 0; n < 256; n++) begin
      d = 8'($urandom);
      expect_byte(d);
      send_frame(d, 1'b1, BIT_NS);
      #($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 30) * CLK_NS);
    end
    drain("rand_drain");

    chk("valid_total", n_valid_seen, n_valid_exp);
    chk("err_total", n_err_seen, n_err_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
